// File: rtl/alpha_ced_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alpha_ced_ctrl
// Description : Byte-row rotation (alpha / inverse alpha) over a 4x4 byte
//               state, with an optional concurrent-error-detection pass that
//               undoes the rotation and compares against the original input.
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_ced_ctrl #(
    parameter int CHECK_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [1:0]   in_cnt,
    input  logic         in_dir,
    input  logic         inj_err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_err,
    output logic [7:0]   err_cnt,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One rotation step on every row; inv selects the inverse direction.
    function automatic logic [127:0] alpha_step(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        int           src;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                src = inv ? ((col + 3) % 4) : ((col + 1) % 4);
                r[8*(4*row+col) +: 8] = s[8*(4*row+src) +: 8];
            end
        end
        return r;
    endfunction

    state_t         state_q,     state_d;
    logic [127:0]   w_q,         w_d;
    logic [127:0]   o_q,         o_d;
    logic [127:0]   c_q,         c_d;
    logic [1:0]     k_q,         k_d;
    logic [1:0]     cnt_q,       cnt_d;
    logic           dir_q,       dir_d;
    logic           inj_q,       inj_d;
    logic [127:0]   out_state_q, out_state_d;
    logic           out_err_q,   out_err_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     err_cnt_q,   err_cnt_d;
    logic           busy_q,      busy_d;

    // A pending injection flips bit 0 once: on the first inverse step, or at
    // the compare itself when there are no steps to take.
    logic [127:0]   w_inj_mask;
    logic [127:0]   w_chk_val;
    logic           w_mismatch;

    assign w_inj_mask = {127'd0, inj_q};
    assign w_chk_val  = c_q ^ w_inj_mask;
    assign w_mismatch = (w_chk_val != o_q);

    // Next-state and datapath decode for the whole controller.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        o_d         = o_q;
        c_d         = c_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        inj_d       = inj_q;
        out_state_d = out_state_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        err_cnt_d   = err_cnt_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_d       = in_state;
                    o_d       = in_state;
                    k_d       = in_cnt;
                    cnt_d     = in_cnt;
                    dir_d     = in_dir;
                    inj_d     = inj_err;
                    out_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_FWD;
                end
            end
            ST_FWD: begin
                if (k_q != 2'd0) begin
                    w_d = alpha_step(w_q, dir_q);
                    k_d = k_q - 2'd1;
                end else begin
                    out_state_d = w_q;
                    c_d         = w_q;
                    k_d         = cnt_q;
                    if (CHECK_EN != 0) begin
                        state_d = ST_CHK;
                    end else begin
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_CHK: begin
                if (k_q != 2'd0) begin
                    c_d   = alpha_step(c_q, ~dir_q) ^ w_inj_mask;
                    inj_d = 1'b0;
                    k_d   = k_q - 2'd1;
                end else begin
                    c_d         = w_chk_val;
                    inj_d       = 1'b0;
                    out_err_d   = w_mismatch;
                    out_valid_d = 1'b1;
                    if (w_mismatch && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            o_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            inj_q       <= 1'b0;
            out_state_q <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            o_q         <= o_d;
            c_q         <= c_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            inj_q       <= inj_d;
            out_state_q <= out_state_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alpha_ced_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alpha_ced_ctrl
// Description : Directed, table-driven bench for alpha_ced_ctrl with one
//               checking instance and one instance built without the check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alpha_ced_ctrl;

    localparam logic [127:0] C_PAT    = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] C_PAT_A1 = 128'h0c0f0e0d_080b0a09_04070605_00030201;
    localparam logic [127:0] C_PAT_I1 = 128'h0e0d0c0f_0a09080b_06050407_02010003;
    localparam logic [127:0] C_RND    = 128'h0123456789abcdef_fedcba9876543210;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_valid0;
    logic         out_ready, out_ready0;
    logic [127:0] in_state;
    logic [1:0]   in_cnt;
    logic         in_dir, inj_err;

    logic         in_ready, out_valid, out_err, busy;
    logic [127:0] out_state;
    logic [7:0]   err_cnt;
    logic         in_ready0, out_valid0, out_err0, busy0;
    logic [127:0] out_state0;
    logic [7:0]   err_cnt0;

    int           tests = 0;
    int           fails = 0;
    logic [7:0]   exp_ec;

    always #5 clk = ~clk;

    alpha_ced_ctrl #(.CHECK_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_cnt(in_cnt), .in_dir(in_dir), .inj_err(inj_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_err(out_err), .err_cnt(err_cnt), .busy(busy)
    );

    alpha_ced_ctrl #(.CHECK_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_state(in_state), .in_cnt(in_cnt), .in_dir(in_dir), .inj_err(inj_err),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_state(out_state0),
        .out_err(out_err0), .err_cnt(err_cnt0), .busy(busy0)
    );

    typedef struct {
        logic [127:0] st;
        logic [1:0]   cnt;
        logic         dir;
        logic         inj;
        logic [127:0] exp_st;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[9];

    // Closed-form n-step rotation: row r, column c takes column c+n (or c-n).
    function automatic logic [127:0] rot_model(input logic [127:0] s, input int n, input logic inv);
        logic [127:0] r;
        int           sh;
        r  = '0;
        sh = inv ? (4 - n) % 4 : n % 4;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[8*(4*row+col) +: 8] = s[8*(4*row+((col+sh)%4)) +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_req(input bit which, input logic [127:0] st, input logic [1:0] cnt,
                            input logic dir, input logic inj);
        int guard;
        guard = 0;
        @(negedge clk);
        in_state = st; in_cnt = cnt; in_dir = dir; inj_err = inj;
        if (which) in_valid0 = 1'b1; else in_valid = 1'b1;
        while (!(which ? in_ready0 : in_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_valid0 = 1'b0;
        // Data changes while busy must not disturb the operation.
        in_state = ~st; in_cnt = ~cnt; in_dir = ~dir; inj_err = ~inj;
    endtask

    task automatic wait_valid(input bit which, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(which ? out_valid0 : out_valid) && lat < 60);
        if (!(which ? out_valid0 : out_valid)) begin
            tests++; fails++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1");
            lat = -1;
        end
    endtask

    task automatic complete(input bit which);
        @(negedge clk);
        if (which) out_ready0 = 1'b1; else out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0; out_ready0 = 1'b0;
        check("valid_drop", which ? out_valid0 : out_valid, 1'b0);
        check("ready_after_done", which ? in_ready0 : in_ready, 1'b1);
        check("busy_after_done", which ? busy0 : busy, 1'b0);
    endtask

    initial begin
        int           lat;
        logic [127:0] snap;
        logic         saw_valid;

        rst_n = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b0; out_ready0 = 1'b0;
        in_state = '0; in_cnt = '0; in_dir = 1'b0; inj_err = 1'b0;
        exp_ec = 8'd0;

        vecs[0] = '{C_PAT, 2'd1, 1'b0, 1'b0, C_PAT_A1, 1'b0, 4};
        vecs[1] = '{C_PAT, 2'd1, 1'b1, 1'b0, C_PAT_I1, 1'b0, 4};
        vecs[2] = '{C_PAT, 2'd3, 1'b0, 1'b0, C_PAT_I1, 1'b0, 8};
        vecs[3] = '{C_PAT, 2'd0, 1'b0, 1'b0, C_PAT,    1'b0, 2};
        vecs[4] = '{C_RND, 2'd2, 1'b1, 1'b0, rot_model(C_RND, 2, 1'b1), 1'b0, 6};
        vecs[5] = '{C_RND, 2'd3, 1'b1, 1'b0, rot_model(C_RND, 3, 1'b1), 1'b0, 8};
        vecs[6] = '{C_RND, 2'd2, 1'b0, 1'b1, rot_model(C_RND, 2, 1'b0), 1'b1, 6};
        vecs[7] = '{C_PAT, 2'd0, 1'b1, 1'b1, C_PAT,    1'b1, 2};
        vecs[8] = '{C_RND, 2'd1, 1'b0, 1'b0, rot_model(C_RND, 1, 1'b0), 1'b0, 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_err_cnt", err_cnt, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_in_ready0", in_ready0, 1'b1);

        // Table of single operations on the checking instance.
        for (int i = 0; i < 9; i++) begin
            send_req(0, vecs[i].st, vecs[i].cnt, vecs[i].dir, vecs[i].inj);
            check("busy_running", busy, 1'b1);
            wait_valid(0, lat);
            check($sformatf("v%0d_state", i), out_state, vecs[i].exp_st);
            check($sformatf("v%0d_err", i), out_err, vecs[i].exp_err);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].exp_err && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            check($sformatf("v%0d_err_cnt", i), err_cnt, exp_ec);
            complete(0);
        end

        // Hand-computed row words for the sequential-byte pattern.
        send_req(0, C_PAT, 2'd1, 1'b0, 1'b0);
        wait_valid(0, lat);
        check("row0_alpha", out_state[31:0], 32'h00030201);
        check("row3_alpha", out_state[127:96], 32'h0c0f0e0d);
        complete(0);

        // Back-pressure: outputs hold, no new accept, for five cycles.
        send_req(0, C_RND, 2'd2, 1'b0, 1'b0);
        wait_valid(0, lat);
        snap = rot_model(C_RND, 2, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_state = C_PAT;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_state", out_state, snap);
            check("hold_err", out_err, 1'b0);
            check("hold_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        complete(0);

        // Err counter saturation with injected faults at cnt = 0.
        for (int j = 0; j < 256; j++) begin
            send_req(0, C_RND, 2'd0, 1'b0, 1'b1);
            wait_valid(0, lat);
            check("sat_out_err", out_err, 1'b1);
            if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            check("sat_err_cnt_model", err_cnt, exp_ec);
            complete(0);
        end
        check("sat_err_cnt_ff", err_cnt, 8'hFF);

        // Reset pulse while in CHK aborts the operation.
        send_req(0, C_PAT, 2'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid_in_rst", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_err_cnt", err_cnt, 8'd0);
        check("abort_out_state", out_state, 128'd0);
        exp_ec = 8'd0;
        saw_valid = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", saw_valid, 1'b0);
        send_req(0, C_PAT, 2'd1, 1'b0, 1'b0);
        wait_valid(0, lat);
        check("post_abort_state", out_state, C_PAT_A1);
        check("post_abort_latency", lat, 4);
        check("post_abort_err", out_err, 1'b0);
        complete(0);

        // Instance built without the check pass.
        send_req(1, C_PAT, 2'd0, 1'b0, 1'b0);
        wait_valid(1, lat);
        check("nochk_cnt0_latency", lat, 1);
        check("nochk_cnt0_state", out_state0, C_PAT);
        complete(1);
        send_req(1, C_RND, 2'd2, 1'b1, 1'b1);
        wait_valid(1, lat);
        check("nochk_cnt2_latency", lat, 3);
        check("nochk_cnt2_state", out_state0, rot_model(C_RND, 2, 1'b1));
        check("nochk_inj_err", out_err0, 1'b0);
        check("nochk_err_cnt", err_cnt0, 8'd0);
        complete(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alpha_ced_ctrl.md
ALPHA_CED_CTRL -- requirements
Module: alpha_ced_ctrl

Interface
REQ-001 SHALL have parameter CHECK_EN, default 1: 1 = run the inverse-permutation check pass, 0 = skip it.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1 bit: request present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port in_state, input, 128 bits: byte b[r][c] at bits [8*(4r+c)+7 : 8*(4r+c)], with r and c in 0..3.
REQ-007 SHALL have port in_cnt, input, 2 bits: number of rotation steps, 0..3.
REQ-008 SHALL have port in_dir, input, 1 bit: 0 = alpha, 1 = inverse alpha.
REQ-009 SHALL have port inj_err, input, 1 bit: fault-injection request, sampled at accept.
REQ-010 SHALL have port out_valid, output, 1 bit: result held on the outputs.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_state, output, 128 bits: permuted state, same byte mapping as in_state.
REQ-013 SHALL have port out_err, output, 1 bit: check mismatch for this result.
REQ-014 SHALL have port err_cnt, output, 8 bits: saturating count of detected errors.
REQ-015 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-016 SHALL define the alpha step, per row r, as out[r][c] = in[r][(c+1) mod 4].
REQ-017 SHALL define the inverse-alpha step, per row r, as out[r][c] = in[r][(c+3) mod 4].
REQ-018 SHALL implement FSM states IDLE, FWD, CHK and DONE.
REQ-019 SHALL drive in_ready high only in IDLE; accept occurs on an edge where in_valid and in_ready are both high.
REQ-020 SHALL, on accept, load W <= in_state, O <= in_state, step counter k <= in_cnt, and latch in_cnt, in_dir and inj_err, then enter FWD.
REQ-021 SHALL, in FWD with k != 0, apply the selected step to W and decrement k, one step per cycle.
REQ-022 SHALL, in FWD with k == 0, load out_state <= W, C <= W and k <= latched cnt, then enter CHK, or enter DONE when CHECK_EN = 0.
REQ-023 SHALL, in CHK with k != 0, apply the opposite step to C and decrement k; on the first CHK step, when inj_err was latched, also XOR bit 0 of the step result.
REQ-024 SHALL, in CHK with k == 0, set out_err <= (C != O), increment err_cnt when out_err is set, and enter DONE.
REQ-025 SHALL, when cnt = 0 with inj_err latched, still flip bit 0 of C at the CHK k == 0 edge, before the compare.
REQ-026 SHALL hold out_valid high in DONE, keeping out_state and out_err stable until out_valid and out_ready are both high on an edge.
REQ-027 SHALL return to IDLE on that completing edge; out_valid SHALL drop and in_ready SHALL rise in the next cycle, with no back-to-back accept in the completing cycle.
REQ-028 SHALL give a latency from the accept edge to the out_valid edge of 2*cnt+2 cycles when CHECK_EN = 1, and cnt+1 cycles when CHECK_EN = 0.
REQ-029 SHALL never set out_err, and never increment err_cnt, when CHECK_EN = 0.
REQ-030 SHALL saturate err_cnt at 8'hFF with no wrap.
REQ-031 SHALL ignore in_valid and all in_* data while busy.
REQ-032 SHALL ignore out_ready outside DONE.

Reset
REQ-033 SHALL, on any edge with rst_n low, set state to IDLE, set out_valid, out_err, busy and err_cnt to 0, and clear out_state, W, O, C and k to 0.
REQ-034 SHALL give rst_n priority over every other event.
REQ-035 SHALL, when reset is asserted during FWD, CHK or DONE, abort the operation with no result delivered and in_ready high in the first cycle after rst_n returns high.
REQ-036 SHALL hold in_ready high from the first cycle after reset release.

Verification
REQ-037 SHALL cover: b[r][c] = 4r+c, cnt = 1, dir = 0 -> row0 = 01 02 03 00, row3 = 0d 0e 0f 0c, out_err = 0, out_valid 4 cycles after accept.
REQ-038 SHALL cover: same state, cnt = 1, dir = 1 -> row0 = 03 00 01 02; cnt = 3, dir = 0 -> identical result, with latency 8.
REQ-039 SHALL cover: cnt = 0 -> out_state = in_state, latency 2; with CHECK_EN = 0 -> latency 1.
REQ-040 SHALL cover: inj_err = 1 with cnt = 2 and with cnt = 0 -> out_err = 1 and err_cnt increments by 1; 256 such injected operations -> err_cnt = FF, held.
REQ-041 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable and in_ready low; completion -> in_ready high in the following cycle.
REQ-042 SHALL cover: rst_n low for 1 cycle during CHK -> out_valid never rises, err_cnt = 0, and the next request completes normally.
